// File: rtl/instr_emit_pkg.sv
// Shared widths, format/state encodings and the field-to-word packer for instr_emit.
package instr_emit_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned NIB_SIZE   = 4;
  localparam int unsigned BYTE_SIZE  = 8;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ALUOP_W    = 3;
  localparam int unsigned FMT_W      = 2;

  typedef enum logic [FMT_W-1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_S   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef struct packed {
    fmt_e                 fmt;
    logic                 isaluop;
    logic [ALUOP_W-1:0]   aluop;
    logic [NIB_SIZE-1:0]  opcode;
    logic [NIB_SIZE-1:0]  reg1;
    logic [NIB_SIZE-1:0]  reg2;
    logic [NIB_SIZE-1:0]  reg3;
    logic [BYTE_SIZE-1:0] bigval;
    logic [NIB_SIZE-1:0]  smallval;
  } instr_fields_t;

  // Pack decoded fields MSB-first; the reserved format falls back to the R layout.
  function automatic word_t encode_word(instr_fields_t f);
    logic [NIB_SIZE-1:0] op;
    word_t               w;
    op = f.isaluop ? {1'b1, f.aluop} : f.opcode;
    case (f.fmt)
      FMT_I:   w = {op, f.reg1, f.bigval};
      FMT_S:   w = {op, f.reg1, f.reg2, f.smallval};
      default: w = {op, f.reg1, f.reg2, f.reg3};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_emit_if.sv
// Field-input handshake plus instruction-memory write port of instr_emit.
interface instr_emit_if;
  import instr_emit_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [FMT_W-1:0]      fmt;
  logic                  isaluop;
  logic [ALUOP_W-1:0]    aluop;
  logic [NIB_SIZE-1:0]   opcode;
  logic [NIB_SIZE-1:0]   reg1;
  logic [NIB_SIZE-1:0]   reg2;
  logic [NIB_SIZE-1:0]   reg3;
  logic [BYTE_SIZE-1:0]  bigval;
  logic [NIB_SIZE-1:0]   smallval;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  mem_ready;

  modport master (
    output in_valid, fmt, isaluop, aluop, opcode, reg1, reg2, reg3, bigval, smallval,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, fmt, isaluop, aluop, opcode, reg1, reg2, reg3, bigval, smallval,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/instr_emit_fifo.sv
// Synchronous FIFO buffering encoded words between field input and memory writes.
module instr_emit_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (push_i) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end
  end

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/instr_emit.sv
// Instruction encoder/writer: packs fields into words and streams them to consecutive addresses.
// Optional build macro INSTR_EMIT_CHECK_EN enables rejection of illegal words with an err pulse.
module instr_emit
  import instr_emit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  flush,
  instr_emit_if.slave           bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  instr_fields_t         fields_c;
  word_t                 enc_word_c;
  word_t                 fifo_head_c;
  logic                  fifo_full_c;
  logic                  fifo_empty_c;
  logic                  accept_c;
  logic                  reject_c;
  logic                  push_c;
  logic                  pop_c;

  always_comb begin
    fields_c          = '0;
    fields_c.fmt      = fmt_e'(bus.fmt);
    fields_c.isaluop  = bus.isaluop;
    fields_c.aluop    = bus.aluop;
    fields_c.opcode   = bus.opcode;
    fields_c.reg1     = bus.reg1;
    fields_c.reg2     = bus.reg2;
    fields_c.reg3     = bus.reg3;
    fields_c.bigval   = bus.bigval;
    fields_c.smallval = bus.smallval;
  end

  assign enc_word_c = encode_word(fields_c);

  assign bus.in_ready = (state_q == ST_RUN) && !fifo_full_c;
  assign accept_c     = bus.in_valid && bus.in_ready;

`ifdef INSTR_EMIT_CHECK_EN
  // Reserved format and non-ALU opcodes in the ALU range are consumed but dropped.
  assign reject_c = (fields_c.fmt == FMT_RSV) || (!fields_c.isaluop && fields_c.opcode[NIB_SIZE-1]);
`else
  assign reject_c = 1'b0;
`endif

  assign push_c = accept_c && !reject_c;

  assign bus.mem_we   = !fifo_empty_c && (state_q != ST_IDLE);
  assign pop_c        = bus.mem_we && bus.mem_ready;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = bus.mem_we ? fifo_head_c : '0;

  instr_emit_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (enc_word_c),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Session FSM with write-address/count tracking; start wins over a simultaneous flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= accept_c && reject_c;
      if (pop_c) begin
        addr_q  <= addr_q + ADDR_WIDTH'(1);
        count_q <= count_q + (ADDR_WIDTH + 1)'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            addr_q  <= base_addr;
            count_q <= '0;
          end
        end
        ST_RUN: begin
          if (flush) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: doc/instr_emit.md
# instr_emit

Instruction encoder/writer: accepts decoded instruction fields over a valid/ready handshake, packs them into WORD_SIZE instruction words and writes them to consecutive instruction-memory addresses. It produces the words that `instr_fetch` reads and `instr_decode` splits apart, and is used by the program loader and self-checking benches. A small FIFO decouples field input from memory write backpressure.

## Interface
- WORD_SIZE, 16, instruction word width
- NIB_SIZE, 4, opcode/register field width
- BYTE_SIZE, 8, bigval width
- ADDR_WIDTH, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)

- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: load base_addr, begin session (IDLE only)
- base_addr  in  ADDR_WIDTH  first write address
- flush  in  1  pulse: stop accepting, drain FIFO, end session
- in_valid / in_ready  in / out  1 / 1  field handshake
- fmt  in  2  0=R {op,r1,r2,r3}, 1=I {op,r1,bigval}, 2=S {op,r1,r2,smallval}, 3=reserved
- isaluop  in  1  1: opcode field forced to {1'b1, aluop}
- aluop  in  3  ALU operation
- opcode, reg1, reg2, reg3  in  NIB_SIZE each  fields
- bigval  in  BYTE_SIZE;  smallval  in  NIB_SIZE
- mem_we  out  1  write request
- mem_addr  out  ADDR_WIDTH;  mem_data  out  WORD_SIZE
- mem_ready  in  1  write accepted this cycle when mem_we=1
- count  out  ADDR_WIDTH+1  words written this session
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at DRAIN→IDLE
- err  out  1  one-cycle pulse on rejected word (see Configuration)

## Operation
- States IDLE, RUN, DRAIN. IDLE→RUN on start (addr←base_addr, count←0). RUN→DRAIN on flush. DRAIN→IDLE when FIFO empty and no write pending; done pulses that cycle.
- start outside IDLE ignored; flush outside RUN ignored; start+flush together in IDLE: start wins, flush ignored.
- in_ready = (state==RUN) && FIFO not full; no same-cycle bypass when full.
- Handshake in the cycle flush is seen still completes.
- Encoding: op = isaluop ? {1'b1,aluop} : opcode; word[15:12]=op; remaining fields per fmt, MSB first.
- mem_we = FIFO not empty && state ≠ IDLE; mem_data = FIFO head; mem_addr = addr. On mem_we && mem_ready: pop, addr++, count++.
- addr wraps 2^ADDR_WIDTH−1 → 0; count wraps at 2^(ADDR_WIDTH+1).
- Simultaneous push and pop allowed (including at full−1/empty+1); occupancy unchanged.

## Timing
- Reset: state IDLE, FIFO empty, addr=0, count=0; in_ready, mem_we, busy, done, err = 0; mem_data=0.
- Latency: accepted at edge N → mem_we=1 in cycle N+1 (if FIFO was empty).
- mem_we/mem_addr/mem_data stable until mem_ready=1.
- Reset mid-session: FIFO contents discarded, no further writes.
- Sustained throughput 1 word/cycle with mem_ready held 1.

## Configuration
- INSTR_EMIT_CHECK_EN defined: fmt=3, or isaluop=0 with opcode[3]=1, rejects the word: handshake completes, nothing pushed, err pulses next cycle.
- Undefined: no checks; fmt=3 encodes as R; err tied 0.

## Structure
- Shared package/header (parameters.v): WORD_SIZE, NIB_SIZE, BYTE_SIZE, fmt codes FMT_R/FMT_I/FMT_S/FMT_RSV, state encodings.
- Sub-module instr_emit_fifo: synchronous FIFO, push/pop/full/empty, WORD_SIZE × FIFO_DEPTH.

## Test plan
- start base_addr=0x10; R op=2 r1=1 r2=3 r3=4 -> mem_addr 0x10, mem_data 0x2134, count=1.
- isaluop=1 aluop=5, R regs 1,2,3 -> 0xD123; I op=4 r1=7 big=0xA5 -> 0x47A5; S op=6 r1=2 r2=3 small=9 -> 0x6239 at consecutive addresses.
- mem_ready=0, push 5 words -> in_ready drops after 4; release -> 4 writes in order, then 5th accepted.
- base_addr=0xFE, 3 words -> addrs 0xFE, 0xFF, 0x00.
- flush with 3 queued -> 3 writes, done one pulse, busy=0; further in_valid not accepted.
- CHECK_EN: fmt=3 -> err pulse, no write, count unchanged; without macro -> written as R; rst_n low mid-drain -> mem_we=0 immediately.
